// File: rtl/twiddle_mul.sv
// ---------------------------------------------------------------------------
// twiddle_mul
//   Sits right after a radix-2 butterfly. The sum path (din1) is delayed to
//   match the multiplier and sign-extended. The difference path (din2) is
//   multiplied by W_N^k = e^(-j2*pi*k/N), with rounding to nearest (half-up).
//   Data and valid both have exactly 3 cycles of latency. The pipeline never
//   stalls. A bubble gives valid_out = 0, and the output registers keep
//   their last value.
//
//   Optional feature: define TWIDDLE_SAT_EN to clamp the product path to the
//   OUT_WIDTH range. When it is undefined, the product path wraps
//   (two's complement). The sum path is never saturated or scaled.
//
//   Twiddle table: each word is {c, d}, with c = round(2^TW_FRAC*cos) and
//   d = -round(2^TW_FRAC*sin). The table is built at elaboration from a
//   fixed-point Taylor series, so the design needs no external file.
//   ROM_FILE names the equivalent hex memory image, which off-line tools use.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   sync_clr   frame restart; the current sample (if valid) uses index 0
//   din1_re/im butterfly sum path          (IN_WIDTH, signed)
//   din2_re/im butterfly difference path   (IN_WIDTH, signed)
//   valid_in   input qualifier
//   dout1_re/im sum path, delayed 3 cycles (OUT_WIDTH, signed)
//   dout2_re/im difference path x W        (OUT_WIDTH, signed)
//   valid_out  output qualifier
// ---------------------------------------------------------------------------
module twiddle_mul #(
  parameter int    IN_WIDTH  = 10,
  parameter int    OUT_WIDTH = 11,
  parameter int    TW_WIDTH  = 9,
  parameter int    TW_FRAC   = 7,
  parameter int    N_POINT   = 512,
  parameter int    STAGE     = 0,
  parameter string ROM_FILE  = "twiddle_512.hex"
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync_clr,
  input  logic signed [IN_WIDTH-1:0]  din1_re,
  input  logic signed [IN_WIDTH-1:0]  din1_im,
  input  logic signed [IN_WIDTH-1:0]  din2_re,
  input  logic signed [IN_WIDTH-1:0]  din2_im,
  input  logic                        valid_in,
  output logic signed [OUT_WIDTH-1:0] dout1_re,
  output logic signed [OUT_WIDTH-1:0] dout1_im,
  output logic signed [OUT_WIDTH-1:0] dout2_re,
  output logic signed [OUT_WIDTH-1:0] dout2_im,
  output logic                        valid_out
);

  localparam int DEPTH = N_POINT / 2;
  localparam int CW    = $clog2(DEPTH);
  localparam int PW    = IN_WIDTH + TW_WIDTH;
  localparam int SW    = PW + 1;
  localparam int WW    = 2 * TW_WIDTH;

  localparam logic [CW-1:0]        CNT_LAST = CW'((DEPTH >> STAGE) - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic signed [SW-1:0] RND_HALF = SW'(64'sd1 <<< (TW_FRAC - 1));
  localparam logic signed [SW-1:0] SAT_HI   = SW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_LO   = SW'(-(64'sd1 <<< (OUT_WIDTH - 1)));
  localparam longint               PI_Q28   = 64'sd843314857;  // round(pi * 2^28)

  // Twiddle word for index k. Sine and cosine come from Taylor series in Q28.
  // Twelve terms keep the error far below one output LSB over [0, pi).
  function automatic logic [WW-1:0] tw_word(input int k);
    longint x;
    longint ts;
    longint tc;
    longint s;
    longint c;
    longint cr;
    longint sr;
    x  = (64'sd2 * PI_Q28 * longint'(k)) / longint'(N_POINT);
    ts = x;
    s  = x;
    tc = 64'sd1 <<< 28;
    c  = tc;
    for (int n = 1; n <= 12; n++) begin
      ts = (ts * x) >>> 28;
      ts = (ts * x) >>> 28;
      ts = -ts / longint'((2 * n) * (2 * n + 1));
      tc = (tc * x) >>> 28;
      tc = (tc * x) >>> 28;
      tc = -tc / longint'((2 * n - 1) * (2 * n));
      s  = s + ts;
      c  = c + tc;
    end
    // Round to nearest: floor(v * 2^TW_FRAC + 0.5) in Q28.
    cr = ((c <<< TW_FRAC) + (64'sd1 <<< 27)) >>> 28;
    sr = ((s <<< TW_FRAC) + (64'sd1 <<< 27)) >>> 28;
    tw_word = {TW_WIDTH'(cr), TW_WIDTH'(-sr)};
  endfunction

  // Bring a rounded product into OUT_WIDTH: clamp it, or wrap it.
  function automatic logic signed [OUT_WIDTH-1:0] fit_out(input logic signed [SW-1:0] v);
`ifdef TWIDDLE_SAT_EN
    if (v > SAT_HI) begin
      fit_out = OUT_WIDTH'(SAT_HI);
    end else if (v < SAT_LO) begin
      fit_out = OUT_WIDTH'(SAT_LO);
    end else begin
      fit_out = OUT_WIDTH'(v);
    end
`else
    fit_out = OUT_WIDTH'(v);
`endif
  endfunction

  // Constant twiddle table.
  logic [WW-1:0] rom_s [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [WW-1:0] WORD = tw_word(g);
    assign rom_s[g] = WORD;
  end

  logic [CW-1:0] cnt_q, cnt_d, cnt_base_s, idx_s;

  logic signed [IN_WIDTH-1:0] d1re_q1, d1im_q1, a_q1, b_q1;
  logic [WW-1:0]              tw_q1;
  logic                       v_q1;
  logic signed [TW_WIDTH-1:0] tw_c_s, tw_d_s;

  logic signed [IN_WIDTH-1:0] d1re_q2, d1im_q2;
  logic signed [PW-1:0]       ac_q2, bd_q2, ad_q2, bc_q2;
  logic                       v_q2;

  logic signed [SW-1:0]        re_s, im_s, re_rnd_s, im_rnd_s, re_sh_s, im_sh_s;
  logic signed [OUT_WIDTH-1:0] dout1_re_q, dout1_im_q, dout2_re_q, dout2_im_q;
  logic signed [OUT_WIDTH-1:0] dout1_re_d, dout1_im_d, dout2_re_d, dout2_im_d;
  logic                        valid_q;

  // Index counter next state. sync_clr forces the current sample to index 0.
  always_comb begin
    cnt_base_s = sync_clr ? {CW{1'b0}} : cnt_q;
    idx_s      = cnt_base_s << STAGE;  // the shift is truncated to CW bits, so it is taken mod N/2
    if (valid_in) begin
      if (cnt_base_s == CNT_LAST) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_base_s + CNT_ONE;
      end
    end else if (sync_clr) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Split the registered ROM word into its cos and -sin halves.
  always_comb begin
    tw_c_s = $signed(tw_q1[WW-1:TW_WIDTH]);
    tw_d_s = $signed(tw_q1[TW_WIDTH-1:0]);
  end

  // P3 combine, round half-up, fit. Output registers load only on valid.
  always_comb begin
    re_s     = SW'(ac_q2) - SW'(bd_q2);
    im_s     = SW'(ad_q2) + SW'(bc_q2);
    re_rnd_s = re_s + RND_HALF;
    im_rnd_s = im_s + RND_HALF;
    re_sh_s  = re_rnd_s >>> TW_FRAC;
    im_sh_s  = im_rnd_s >>> TW_FRAC;
    if (v_q2) begin
      dout1_re_d = OUT_WIDTH'(d1re_q2);
      dout1_im_d = OUT_WIDTH'(d1im_q2);
      dout2_re_d = fit_out(re_sh_s);
      dout2_im_d = fit_out(im_sh_s);
    end else begin
      dout1_re_d = dout1_re_q;
      dout1_im_d = dout1_im_q;
      dout2_re_d = dout2_re_q;
      dout2_im_d = dout2_im_q;
    end
  end

  // Counter and the three pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= {CW{1'b0}};
      d1re_q1    <= {IN_WIDTH{1'b0}};
      d1im_q1    <= {IN_WIDTH{1'b0}};
      a_q1       <= {IN_WIDTH{1'b0}};
      b_q1       <= {IN_WIDTH{1'b0}};
      tw_q1      <= {WW{1'b0}};
      v_q1       <= 1'b0;
      d1re_q2    <= {IN_WIDTH{1'b0}};
      d1im_q2    <= {IN_WIDTH{1'b0}};
      ac_q2      <= {PW{1'b0}};
      bd_q2      <= {PW{1'b0}};
      ad_q2      <= {PW{1'b0}};
      bc_q2      <= {PW{1'b0}};
      v_q2       <= 1'b0;
      dout1_re_q <= {OUT_WIDTH{1'b0}};
      dout1_im_q <= {OUT_WIDTH{1'b0}};
      dout2_re_q <= {OUT_WIDTH{1'b0}};
      dout2_im_q <= {OUT_WIDTH{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      // P1: capture the inputs and read the synchronous ROM.
      d1re_q1    <= din1_re;
      d1im_q1    <= din1_im;
      a_q1       <= din2_re;
      b_q1       <= din2_im;
      tw_q1      <= rom_s[idx_s];
      v_q1       <= valid_in;
      // P2: form the four partial products.
      d1re_q2    <= d1re_q1;
      d1im_q2    <= d1im_q1;
      ac_q2      <= PW'(a_q1) * PW'(tw_c_s);
      bd_q2      <= PW'(b_q1) * PW'(tw_d_s);
      ad_q2      <= PW'(a_q1) * PW'(tw_d_s);
      bc_q2      <= PW'(b_q1) * PW'(tw_c_s);
      v_q2       <= v_q1;
      // P3: register the outputs.
      dout1_re_q <= dout1_re_d;
      dout1_im_q <= dout1_im_d;
      dout2_re_q <= dout2_re_d;
      dout2_im_q <= dout2_im_d;
      valid_q    <= v_q2;
    end
  end

  assign dout1_re  = dout1_re_q;
  assign dout1_im  = dout1_im_q;
  assign dout2_re  = dout2_re_q;
  assign dout2_im  = dout2_im_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_twiddle_mul.sv
// Directed bench for twiddle_mul. Two instances share the stimulus:
//   u0: default parameters (OUT_WIDTH 11, STAGE 0)
//   u1: STAGE 1, OUT_WIDTH 10 (stride and saturation cases)
module tb_twiddle_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync_clr = 1'b0;
  logic valid_in = 1'b0;
  logic signed [9:0] din1_re = 10'sd0, din1_im = 10'sd0, din2_re = 10'sd0, din2_im = 10'sd0;

  logic signed [10:0] u0_d1re, u0_d1im, u0_d2re, u0_d2im;
  logic               u0_vld;
  logic signed [9:0]  u1_d1re, u1_d1im, u1_d2re, u1_d2im;
  logic               u1_vld;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  twiddle_mul u0 (
    .clk(clk), .rst(rst), .sync_clr(sync_clr),
    .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
    .valid_in(valid_in),
    .dout1_re(u0_d1re), .dout1_im(u0_d1im), .dout2_re(u0_d2re), .dout2_im(u0_d2im),
    .valid_out(u0_vld)
  );

  twiddle_mul #(.STAGE(1), .OUT_WIDTH(10)) u1 (
    .clk(clk), .rst(rst), .sync_clr(sync_clr),
    .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
    .valid_in(valid_in),
    .dout1_re(u1_d1re), .dout1_im(u1_d1im), .dout2_re(u1_d2re), .dout2_im(u1_d2im),
    .valid_out(u1_vld)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one input cycle, then return 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic clr,
                       input int d1r, input int d1i, input int d2r, input int d2i);
    valid_in = v;
    sync_clr = clr;
    din1_re  = 10'(d1r);
    din1_im  = 10'(d1i);
    din2_re  = 10'(d2r);
    din2_im  = 10'(d2i);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_u0_vld", int'(u0_vld), 0);
    check_eq("rst_u0_d1re", int'(u0_d1re), 0);
    check_eq("rst_u0_d2re", int'(u0_d2re), 0);
    check_eq("rst_u1_vld", int'(u1_vld), 0);
    rst = 1'b0;
    idle();

    // Reset asserted mid-stream after five valid cycles.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1, 2, 100, 50);
    check_eq("pre_rst_vld", int'(u0_vld), 1);
    check_eq("pre_rst_d1re", int'(u0_d1re), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_vld", int'(u0_vld), 0);
    check_eq("async_rst_d1re", int'(u0_d1re), 0);
    check_eq("async_rst_d1im", int'(u0_d1im), 0);
    check_eq("async_rst_d2re", int'(u0_d2re), 0);
    check_eq("async_rst_d2im", int'(u0_d2im), 0);
    check_eq("async_rst_u1_vld", int'(u1_vld), 0);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq("no_partial_vld", int'(u0_vld), 0);
    end
    // With the counter back at 0, this sample sees W = 1.
    drive(1'b1, 1'b0, 0, 0, 100, 50);
    idle();
    idle();
    check_eq("post_rst_vld", int'(u0_vld), 1);
    check_eq("post_rst_idx0_re", int'(u0_d2re), 100);
    check_eq("post_rst_idx0_im", int'(u0_d2im), 50);

    // Index 0 through sync_clr, with a check on the latency.
    drive(1'b1, 1'b1, -7, 3, 100, 50);
    idle();
    check_eq("lat_early_vld", int'(u0_vld), 0);
    idle();
    check_eq("idx0_vld", int'(u0_vld), 1);
    check_eq("idx0_d2re", int'(u0_d2re), 100);
    check_eq("idx0_d2im", int'(u0_d2im), 50);
    check_eq("idx0_d1re", int'(u0_d1re), -7);
    check_eq("idx0_d1im", int'(u0_d1im), 3);
    check_eq("idx0_u1_d2re", int'(u1_d2re), 100);
    idle();
    check_eq("bubble_vld", int'(u0_vld), 0);
    check_eq("bubble_hold_d2re", int'(u0_d2re), 100);

    // Valid samples 2..129 after the clear. Bubbles here do not move the counter.
    for (int i = 2; i <= 129; i++) begin
      if (i == 33) begin
        drive(1'b1, 1'b0, 0, 0, 511, 511);
        idle();
        idle();
        // u0 uses idx 32, where W = (118,-49).
        check_eq("u0_idx32_re", int'(u0_d2re), 667);
        check_eq("u0_idx32_im", int'(u0_d2im), 275);
        // u1 uses idx 64, where W = (91,-91). This is the saturation case.
`ifdef TWIDDLE_SAT_EN
        check_eq("u1_sat_re", int'(u1_d2re), 511);
`else
        check_eq("u1_wrap_re", int'(u1_d2re), -297);
`endif
        check_eq("u1_sat_im", int'(u1_d2im), 0);
      end else if (i == 65) begin
        drive(1'b1, 1'b0, 0, 0, 100, 50);
        idle();
        idle();
        check_eq("u0_idx64_re", int'(u0_d2re), 107);
        check_eq("u0_idx64_im", int'(u0_d2im), -36);
        check_eq("u1_stride_idx128_re", int'(u1_d2re), 50);
        check_eq("u1_stride_idx128_im", int'(u1_d2im), -100);
      end else if (i == 129) begin
        drive(1'b1, 1'b0, 0, 0, 100, 50);
        idle();
        idle();
        check_eq("u0_idx128_re", int'(u0_d2re), 50);
        check_eq("u0_idx128_im", int'(u0_d2im), -100);
        check_eq("u1_wrap_idx0_re", int'(u1_d2re), 100);
        check_eq("u1_wrap_idx0_im", int'(u1_d2im), 50);
      end else begin
        drive(1'b1, 1'b0, 0, 0, 0, 0);
      end
    end

    // Bubble pattern 1,0,0,1 on the input. The counter should advance by 2 only.
    drive(1'b1, 1'b1, 5, 5, 20, 10);
    idle();
    idle();
    check_eq("pat_vld_0", int'(u0_vld), 1);
    check_eq("pat_a_d2re", int'(u0_d2re), 20);
    drive(1'b1, 1'b0, -512, 511, 100, 50);
    check_eq("pat_vld_1", int'(u0_vld), 0);
    check_eq("pat_hold_d2re", int'(u0_d2re), 20);
    idle();
    check_eq("pat_vld_2", int'(u0_vld), 0);
    idle();
    check_eq("pat_vld_3", int'(u0_vld), 1);
    check_eq("pat_b_idx1_re", int'(u0_d2re), 101);
    check_eq("pat_b_idx1_im", int'(u0_d2im), 48);
    check_eq("pat_b_d1re_sext", int'(u0_d1re), -512);
    check_eq("pat_b_d1im", int'(u0_d1im), 511);
    drive(1'b1, 1'b0, 0, 0, 0, 100);
    idle();
    idle();
    check_eq("cnt_plus2_re", int'(u0_d2re), 2);
    check_eq("cnt_plus2_im", int'(u0_d2im), 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
